// File: rtl/mec_pkg.sv
// Shared constants and helpers for the multi-channel event counter.
// Optional build macro: MULTI_EVT_COUNTER_SATURATE_EN (saturating counters).
package mec_pkg;

    localparam int NCH_DEF   = 4;
    localparam int CNT_W_DEF = 64;
    localparam int PRE_W_DEF = 4;

    // Width of the channel-select bus for a given channel count.
    function automatic int sel_width(input int nch);
        return $clog2(nch);
    endfunction

endpackage

// File: rtl/mec_channel.sv
// One prescaled event-counter channel: count, prescale, divisor, sticky
// overflow and a one-cycle tick that coincides with the new count value.
// Optional build macro: MULTI_EVT_COUNTER_SATURATE_EN makes the counter
// stick at all-ones instead of wrapping to zero.
//
// Strobe semantics: en, clr and div_we are single-cycle qualifiers sampled
// on the rising Clk edge; there is no back-pressure. Priority within a
// cycle is Reset > clr > div_we > en, and a lower-priority strobe that
// loses to a higher one is dropped, not deferred.
module mec_channel
    import mec_pkg::*;
#(
    parameter int CNT_W = 8,
    parameter int PRE_W = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             en,
    input  logic             clr,
    input  logic             div_we,
    input  logic [PRE_W-1:0] div_in,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf,
    output logic             tick
);

    logic [PRE_W-1:0] pre;
    logic [PRE_W-1:0] div;

    logic             pre_done;
    logic             cnt_full;
    logic [CNT_W-1:0] cnt_inc;

    // Prescale terminal condition and the value the counter takes on increment.
    always_comb begin
        pre_done = (pre == div);
        cnt_full = (cnt == {CNT_W{1'b1}});
`ifdef MULTI_EVT_COUNTER_SATURATE_EN
        cnt_inc  = cnt_full ? cnt : cnt + 1'b1;
`else
        cnt_inc  = cnt + 1'b1;
`endif
    end

    // Channel state update in priority order; tick defaults low every cycle.
    always_ff @(posedge Clk) begin
        tick <= 1'b0;
        if (Reset) begin
            cnt <= '0;
            pre <= '0;
            div <= '0;
            ovf <= 1'b0;
        end else if (clr) begin
            cnt <= '0;
            pre <= '0;
            ovf <= 1'b0;
        end else if (div_we) begin
            div <= div_in;
            pre <= '0;
        end else if (en) begin
            if (pre_done) begin
                pre  <= '0;
                cnt  <= cnt_inc;
                tick <= 1'b1;
                if (cnt_full) begin
                    ovf <= 1'b1;
                end
            end else begin
                pre <= pre + 1'b1;
            end
        end
    end

endmodule

// File: rtl/multi_evt_counter.sv
// Multi-channel prescaled event counter top: decodes Sel into per-channel
// strobes and concatenates the channel outputs. Out-of-range Sel values
// select no channel, so the strobes are ignored.
// Optional build macro: MULTI_EVT_COUNTER_SATURATE_EN (saturating counters).
module multi_evt_counter
    import mec_pkg::*;
#(
    parameter  int NCH   = NCH_DEF,
    parameter  int CNT_W = CNT_W_DEF,
    parameter  int PRE_W = PRE_W_DEF,
    localparam int SEL_W = sel_width(NCH)
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 En,
    input  logic [SEL_W-1:0]     Sel,
    input  logic                 Clr,
    input  logic                 DivWe,
    input  logic [PRE_W-1:0]     DivIn,
    output logic [NCH*CNT_W-1:0] Count,
    output logic [NCH-1:0]       Ovf,
    output logic [NCH-1:0]       Tick
);

    logic [NCH-1:0] sel_hit;

    // Per-channel select decode; only values below NCH can match.
    always_comb begin
        sel_hit = '0;
        for (int i = 0; i < NCH; i++) begin
            sel_hit[i] = (Sel == SEL_W'(i));
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        mec_channel #(
            .CNT_W (CNT_W),
            .PRE_W (PRE_W)
        ) u_ch (
            .Clk    (Clk),
            .Reset  (Reset),
            .en     (En    & sel_hit[i]),
            .clr    (Clr   & sel_hit[i]),
            .div_we (DivWe & sel_hit[i]),
            .div_in (DivIn),
            .cnt    (Count[i*CNT_W +: CNT_W]),
            .ovf    (Ovf[i]),
            .tick   (Tick[i])
        );
    end

endmodule

// File: tb/tb_multi_evt_counter.sv
// Self-checking bench for multi_evt_counter: a 4-channel instance and a
// 3-channel instance share the same stimulus and are compared every cycle
// against a behavioural model of the counting rules.
module tb_multi_evt_counter;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        En;
    logic [1:0]  Sel;
    logic        Clr;
    logic        DivWe;
    logic [3:0]  DivIn;
    logic [31:0] Count;
    logic [3:0]  Ovf;
    logic [3:0]  Tick;
    logic [23:0] Count3;
    logic [2:0]  Ovf3;
    logic [2:0]  Tick3;

    int n_vec = 0;
    int n_err = 0;

    // model state: [instance][channel]; instance 0 has 4 channels, 1 has 3
    int  m_cnt [2][4];
    int  m_pre [2][4];
    int  m_div [2][4];
    bit  m_ovf [2][4];
    bit  m_tick[2][4];
    int  m_nch [2] = '{4, 3};

    // ---------------- clock / reset ----------------
    always #5 Clk = ~Clk;

    multi_evt_counter #(.NCH(4), .CNT_W(8), .PRE_W(4)) dut (
        .Clk(Clk), .Reset(Reset), .En(En), .Sel(Sel), .Clr(Clr),
        .DivWe(DivWe), .DivIn(DivIn), .Count(Count), .Ovf(Ovf), .Tick(Tick)
    );

    multi_evt_counter #(.NCH(3), .CNT_W(8), .PRE_W(4)) dut3 (
        .Clk(Clk), .Reset(Reset), .En(En), .Sel(Sel), .Clr(Clr),
        .DivWe(DivWe), .DivIn(DivIn), .Count(Count3), .Ovf(Ovf3), .Tick(Tick3)
    );

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock of the reference model, straight from the counting rules.
    task automatic model_step(input bit rst, input bit en, input bit clr, input bit dwe,
                              input int sel, input int din);
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < m_nch[k]; c++) begin
                m_tick[k][c] = 1'b0;
                if (rst) begin
                    m_cnt[k][c] = 0; m_pre[k][c] = 0; m_div[k][c] = 0; m_ovf[k][c] = 1'b0;
                end else if (sel == c) begin
                    if (clr) begin
                        m_cnt[k][c] = 0; m_pre[k][c] = 0; m_ovf[k][c] = 1'b0;
                    end else if (dwe) begin
                        m_div[k][c] = din; m_pre[k][c] = 0;
                    end else if (en) begin
                        if (m_pre[k][c] == m_div[k][c]) begin
                            m_pre[k][c]  = 0;
                            m_tick[k][c] = 1'b1;
                            if (m_cnt[k][c] == 255) begin
                                m_ovf[k][c] = 1'b1;
`ifdef MULTI_EVT_COUNTER_SATURATE_EN
                                m_cnt[k][c] = 255;
`else
                                m_cnt[k][c] = 0;
`endif
                            end else begin
                                m_cnt[k][c] = m_cnt[k][c] + 1;
                            end
                        end else begin
                            m_pre[k][c] = m_pre[k][c] + 1;
                        end
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        logic [31:0] ec;
        logic [3:0]  eo, et;
        logic [23:0] ec3;
        logic [2:0]  eo3, et3;
        for (int c = 0; c < 4; c++) begin
            ec[c*8 +: 8] = 8'(m_cnt[0][c]);
            eo[c] = m_ovf[0][c];
            et[c] = m_tick[0][c];
        end
        for (int c = 0; c < 3; c++) begin
            ec3[c*8 +: 8] = 8'(m_cnt[1][c]);
            eo3[c] = m_ovf[1][c];
            et3[c] = m_tick[1][c];
        end
        check("count4", Count, ec);
        check("ovf4",   Ovf,   eo);
        check("tick4",  Tick,  et);
        check("count3", Count3, ec3);
        check("ovf3",   Ovf3,   eo3);
        check("tick3",  Tick3,  et3);
    endtask

    // ---------------- driver ----------------
    task automatic step(input bit rst, input bit en, input bit clr, input bit dwe,
                        input int sel, input int din);
        Reset = rst; En = en; Clr = clr; DivWe = dwe;
        Sel = 2'(sel); DivIn = 4'(din);
        model_step(rst, en, clr, dwe, sel, din);
        @(posedge Clk);
        #1;
        compare_all();
    endtask

    task automatic events(input int sel, input int n);
        for (int j = 0; j < n; j++) step(0, 1, 0, 0, sel, 0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        Reset = 1'b1; En = 1'b0; Clr = 1'b0; DivWe = 1'b0; Sel = '0; DivIn = '0;

        // reset state
        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 1, 1, 2, 7);
        check("rst_count", Count, 32'h0);
        check("rst_tick",  Tick,  4'h0);

        // div=0 counts every event, tick each cycle
        events(0, 5);
        check("d0_ch0", Count[7:0], 8'd5);
        check("d0_ch1", Count[31:8], 24'd0);
        step(0, 0, 0, 0, 0, 0);
        check("d0_tick_idle", Tick[0], 1'b0);

        // div=3: one count per 4 events
        step(0, 0, 0, 1, 1, 3);
        events(1, 8);
        check("d3_ch1", Count[15:8], 8'd2);

        // overflow on ch2
        events(2, 255);
        check("pre_wrap_ch2", Count[23:16], 8'hFF);
        check("pre_wrap_ovf", Ovf[2], 1'b0);
        events(2, 1);
`ifdef MULTI_EVT_COUNTER_SATURATE_EN
        check("wrap_ch2", Count[23:16], 8'hFF);
`else
        check("wrap_ch2", Count[23:16], 8'h00);
`endif
        check("wrap_ovf", Ovf[2], 1'b1);
        check("wrap_tick", Tick[2], 1'b1);
        events(2, 3);
        check("ovf_sticky", Ovf[2], 1'b1);

        // clear beats a same-cycle event and keeps the divisor
        step(0, 0, 0, 1, 3, 2);
        events(3, 22);
        check("clr_pre_ch3", Count[31:24], 8'd7);
        step(0, 1, 1, 0, 3, 0);
        check("clr_ch3", Count[31:24], 8'd0);
        check("clr_tick3", Tick[3], 1'b0);
        check("clr_ovf3", Ovf[3], 1'b0);
        events(3, 2);
        check("clr_div_kept_a", Count[31:24], 8'd0);
        events(3, 1);
        check("clr_div_kept_b", Count[31:24], 8'd1);

        // divisor write drops a same-cycle event
        step(0, 1, 0, 1, 0, 1);
        check("dwe_drop_ch0", Count[7:0], 8'd5);

        // reset mid-prescale with competing strobes
        step(0, 0, 0, 1, 1, 5);
        events(1, 2);
        step(1, 1, 0, 1, 1, 5);
        check("rst_mid_count", Count, 32'h0);
        check("rst_mid_ovf", Ovf, 4'h0);
        events(1, 1);
        check("rst_div0_ch1", Count[15:8], 8'd1);

        // out-of-range select on the 3-channel instance
        events(3, 4);
        step(0, 1, 1, 1, 3, 2);
        check("oor_count3", Count3[7:0], 8'd0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            int r;
            bit rst, en, clr, dwe;
            r   = $urandom_range(0, 99);
            rst = (r == 0);
            clr = ($urandom_range(0, 99) < 4);
            dwe = ($urandom_range(0, 99) < 8);
            en  = ($urandom_range(0, 99) < 75);
            step(rst, en, clr, dwe, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/multi_evt_counter.md
MULTI_EVT_COUNTER -- requirements
Module: multi_evt_counter

Interface
REQ-001 Parameter NCH, default 4: number of independent counter channels, 2..16.
REQ-002 Parameter CNT_W, default 64: counter width per channel, 8..64.
REQ-003 Parameter PRE_W, default 4: prescale divisor width per channel, 1..8.
REQ-004 SEL_W SHALL be the localparam $clog2(NCH).
REQ-005 Clk  input  1: clock; reset Reset, synchronous, active-high; clock Clk.
REQ-006 Reset  input  1: synchronous, active-high reset.
REQ-007 En  input  1: event strobe for channel Sel.
REQ-008 Sel  input  SEL_W: channel select for En, Clr and DivWe.
REQ-009 Clr  input  1: clear the selected channel.
REQ-010 DivWe  input  1: write DivIn to the selected channel's divisor.
REQ-011 DivIn  input  PRE_W: divisor value D; the channel counts once per D+1 events.
REQ-012 Count  output  NCH*CNT_W: flattened counters; channel i occupies bits [i*CNT_W +: CNT_W].
REQ-013 Ovf  output  NCH: sticky per-channel overflow flags.
REQ-014 Tick  output  NCH: one-cycle per-channel pulse, asserted in the cycle in which the new Count value is visible.

Function
REQ-015 Each channel SHALL hold cnt (CNT_W bits), pre (PRE_W bits) and div (PRE_W bits) registers; all outputs SHALL be registered.
REQ-016 Per-channel update priority SHALL be Reset > Clr > DivWe > En.
REQ-017 Event handling: with En=1, Sel=i and neither Clr nor DivWe, if pre[i]==div[i] then pre[i]<=0, cnt[i] increments and Tick[i]<=1; otherwise pre[i] increments.
REQ-018 Clr with Sel=i SHALL zero cnt[i], pre[i] and Ovf[i], keep div[i] unchanged, and drop any same-cycle En event.
REQ-019 DivWe with Sel=i SHALL load div[i] from DivIn, zero pre[i], keep cnt[i], and drop any same-cycle En event.
REQ-020 Tick[i] SHALL be 0 in every cycle not immediately following an increment of channel i.
REQ-021 Channels not selected by Sel SHALL hold all state.
REQ-022 If Sel>=NCH, En, Clr and DivWe SHALL have no effect.
REQ-023 Wrap: an increment with cnt[i] all-ones SHALL produce 0 and set Ovf[i]; Ovf[i] SHALL stay set until Clr or Reset.
REQ-024 Latency: Count reflects an accepted event on the first rising Clk edge after the event.

Reset
REQ-025 Reset SHALL zero all cnt, pre, div, Ovf and Tick registers on the next Clk edge, regardless of En, Clr or DivWe.
REQ-026 Reset asserted mid-prescale SHALL discard the partial prescale count.
REQ-027 There SHALL be no asynchronous reset path.

Configuration
REQ-028 With macro MULTI_EVT_COUNTER_SATURATE_EN defined, an increment with cnt[i] all-ones SHALL leave cnt[i] at all-ones and set Ovf[i]; Tick[i] SHALL still pulse.
REQ-029 Without MULTI_EVT_COUNTER_SATURATE_EN, counters SHALL wrap as specified in REQ-023.

Structure
REQ-030 Package mec_pkg SHALL hold the default constants for NCH, CNT_W and PRE_W, plus the SEL_W derivation function.
REQ-031 One channel (cnt, pre, div, Ovf, Tick and the channel-local priority logic) SHALL be sub-module mec_channel, instantiated NCH times via generate.
REQ-032 The top level SHALL only decode Sel into per-channel enables and concatenate the channel outputs.

Verification (NCH=4, CNT_W=8, PRE_W=4 unless stated)
REQ-033 Reset, then En=1, Sel=0 for 5 cycles with div=0 -> Count ch0=5, ch1..3=0; Tick[0] high in 5 consecutive cycles.
REQ-034 DivWe Sel=1 DivIn=3, then 8 cycles of En Sel=1 -> Count ch1=2; Tick[1] pulses after the 4th and 8th events only.
REQ-035 Drive ch2 to 0xFF, then one more En event -> Count ch2=0x00 and Ovf[2]=1; with MULTI_EVT_COUNTER_SATURATE_EN, Count ch2=0xFF and Ovf[2]=1.
REQ-036 Count ch3=7 with div=2 and pre=1, then Clr=1 and En=1 in the same cycle with Sel=3 -> cnt=0, pre=0, Ovf[3]=0, div=2, Tick[3]=0.
REQ-037 Reset asserted while En=1 and DivWe=1 on ch1 -> after one edge all Count=0, Ovf=0 and div=0; the next En event on ch1 increments at once.
REQ-038 NCH=3, Sel=3, En=1, Clr=1 -> no channel changes state.
